// File: rtl/free_list.sv
// free_list: circular FIFO of free physical-register tags feeding rename and reclaiming ROB retires
// Optional feature: define FL_BYPASS_EN to let retiring tags fill empty output slots in the same cycle.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   id_dispatch_num     - tags consumed this cycle (0..2, 3 treated as 2)
//   rob_retire_num      - tags returned this cycle (0..2, 3 treated as 2)
//   rob_retire_tag_a/b  - returned tags, lane a first
//   fl_pr0/fl_pr1       - tags at head and head+1, INVALID_TAG when absent
//   fl_cap              - tags allocatable this cycle, min(available, 2)
//   fl_count            - occupancy 0..NUM_PR
//   fl_underflow        - sticky: dispatch asked for more than fl_cap
//   fl_overflow         - sticky: a retire was dropped because the list was full
module free_list #(
    parameter int         NUM_PR      = 128,
    parameter int         NUM_AR      = 32,
    parameter logic [6:0] INVALID_TAG = 7'h7f
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] id_dispatch_num,
    input  logic [1:0] rob_retire_num,
    input  logic [6:0] rob_retire_tag_a,
    input  logic [6:0] rob_retire_tag_b,
    output logic [6:0] fl_pr0,
    output logic [6:0] fl_pr1,
    output logic [1:0] fl_cap,
    output logic [7:0] fl_count,
    output logic       fl_underflow,
    output logic       fl_overflow
);
    logic [6:0] tags [NUM_PR];
    logic [6:0] head, tail;
    logic [7:0] count;
    logic       underflow, overflow;
    logic [1:0] req, push_req, cap, pop_n, byp, apop, push_want, push_n;
    logic [7:0] room;
    logic [6:0] q0, q1, pr0, pr1, w0;
    logic       low;
`ifdef FL_BYPASS_EN
    logic [7:0] avail;
`endif

    always_comb begin
        req       = id_dispatch_num == 2'd3 ? 2'd2 : id_dispatch_num;
        push_req  = rob_retire_num == 2'd3 ? 2'd2 : rob_retire_num;
        low       = count < 8'd2;
        q0        = count != 8'd0 ? tags[head] : INVALID_TAG;
        q1        = !low ? tags[head + 7'd1] : INVALID_TAG;
`ifdef FL_BYPASS_EN
        // Retiring tags queue up behind whatever is stored, so they fill the first empty slots in lane order.
        avail     = count + {6'd0, push_req};
        cap       = avail >= 8'd2 ? 2'd2 : avail[1:0];
        pr0       = count != 8'd0 ? q0 : push_req != 2'd0 ? rob_retire_tag_a : INVALID_TAG;
        pr1       = !low ? q1
                  : count == 8'd1 ? (push_req != 2'd0 ? rob_retire_tag_a : INVALID_TAG)
                  : (push_req == 2'd2 ? rob_retire_tag_b : INVALID_TAG);
`else
        cap       = low ? count[1:0] : 2'd2;
        pr0       = q0;
        pr1       = q1;
`endif
        pop_n     = req > cap ? cap : req;
`ifdef FL_BYPASS_EN
        // Pops beyond the stored entries consume retiring tags directly; those never touch the array.
        byp       = low && pop_n > count[1:0] ? pop_n - count[1:0] : 2'd0;
`else
        byp       = 2'd0;
`endif
        apop      = pop_n - byp;
        push_want = push_req - byp;
        // Room is measured after this cycle's pops, so a full list that also pops can still accept.
        room      = 8'(NUM_PR) - (count - {6'd0, apop});
        push_n    = {6'd0, push_want} > room ? room[1:0] : push_want;
        w0        = byp == 2'd0 ? rob_retire_tag_a : rob_retire_tag_b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PR; i++)
                tags[i] <= i < NUM_PR - NUM_AR ? 7'(NUM_AR + i) : 7'd0;
            head      <= 7'd0;
            tail      <= 7'(NUM_PR - NUM_AR);
            count     <= 8'(NUM_PR - NUM_AR);
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_n != 2'd0)
                tags[tail] <= w0;
            if (push_n == 2'd2)
                tags[tail + 7'd1] <= rob_retire_tag_b;
            head  <= head + {5'd0, apop};
            tail  <= tail + {5'd0, push_n};
            count <= count - {6'd0, apop} + {6'd0, push_n};
            if (req > cap)
                underflow <= 1'b1;
            if ({6'd0, push_want} > room)
                overflow <= 1'b1;
        end
    end

    assign fl_pr0       = pr0;
    assign fl_pr1       = pr1;
    assign fl_cap       = cap;
    assign fl_count     = count;
    assign fl_underflow = underflow;
    assign fl_overflow  = overflow;
endmodule
